mmc_trigger_sequencer: RTL

Multi-stage trigger sequencer for MMC command-line traffic. Consumes decoded 48-bit command packets from the MMC message capture block (already synchronised into the `clk` domain) and walks a programmable chain of up to four compare stages; `trig_out` fires only when the stages match in order, with an optional inter-stage packet timeout. It sits on the register bus beside the single-compare MMC trigger and drives the same trigger-output mux input.

---
 rtl/mmc_trigger_sequencer.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/mmc_trigger_sequencer.sv
// mmc_trigger_sequencer: multi-stage compare chain over decoded MMC command
// packets. trig_out fires for STRETCH cycles once up to four programmable
// stages have matched in order. An optional timeout, counted in packets,
// returns the chain to stage 0.
module mmc_trigger_sequencer #(
  parameter int STRETCH = 127
) (
  input  logic        clk,
  input  logic        reset_i,
  input  logic [5:0]  reg_address,
  input  logic [15:0] reg_bytecnt,
  input  logic [7:0]  reg_datai,
  output logic [7:0]  reg_datao,
  input  logic [15:0] reg_size,
  input  logic        reg_read,
  input  logic        reg_write,
  input  logic        reg_addrvalid,
  output logic        reg_stream,
  input  logic [5:0]  reg_hypaddress,
  output logic [15:0] reg_hyplen,
  input  logic [47:0] msg_packet,
  input  logic        msg_valid,
  output logic        trig_out,
  output logic [1:0]  seq_stage
);

  localparam logic [5:0] ADDR_STATUS = 6'd60;
  localparam logic [5:0] ADDR_CTRL   = 6'd61;
  localparam logic [5:0] ADDR_STAGES = 6'd62;
  localparam logic [7:0] STRETCH_M1  = 8'(STRETCH - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_FIRE} state_t;

  // Handshake: msg_valid is a one-cycle strobe with no back-pressure. Every
  // cycle it is high, msg_packet is consumed at that clock edge, including
  // strobes on consecutive cycles. A packet arriving while idle or firing
  // is dropped.

  state_t      state;
  logic [1:0]  stage;
  logic [15:0] miss_cnt;
  logic [7:0]  fire_cnt;
  logic [7:0]  stretch_cnt;

  logic [1:0]  ctrl_last;
  logic        ctrl_rearm;
  logic [15:0] ctrl_timeout;
  logic [63:0] stage_cfg [4];

  logic        arm_strobe;
  logic        abort_strobe;
  logic [63:0] cur_cfg;
  logic        arg_ok;
  logic        cmd_ok;
  logic        tx_ok;
  logic        stage_match;
  logic [15:0] miss_next;
  logic [15:0] status_word;
  logic [31:0] ctrl_word;
  logic [7:0]  rd_byte;
  logic        unused_inputs;

  assign reg_stream   = 1'b0;
  assign seq_stage    = stage;
  assign arm_strobe   = reg_write && (reg_address == ADDR_CTRL) &&
                        (reg_bytecnt == 16'd0) && reg_datai[2];
  assign abort_strobe = reg_write && (reg_address == ADDR_CTRL) &&
                        (reg_bytecnt == 16'd0) && reg_datai[4];
  assign miss_next    = miss_cnt + 16'd1;
  assign status_word  = {fire_cnt, 4'b0, (state == ST_FIRE), (state != ST_IDLE), stage};
  assign ctrl_word    = {ctrl_timeout, 12'b0, ctrl_rearm, 1'b0, ctrl_last};
  assign unused_inputs = ^{reg_size, reg_addrvalid, msg_packet[47], msg_packet[7:0],
                           cur_cfg[22:3]};

  // Compare the incoming packet against the stage currently being waited on.
  always_comb begin
    cur_cfg = stage_cfg[stage];
    arg_ok  = 1'b1;
    if (cur_cfg[2]) begin
      case (cur_cfg[24:23])
        2'b00:   arg_ok = (msg_packet[39:8] == cur_cfg[63:32]);
        2'b01:   arg_ok = (msg_packet[39:8] != cur_cfg[63:32]);
        2'b10:   arg_ok = (msg_packet[39:8] <  cur_cfg[63:32]);
        default: arg_ok = (msg_packet[39:8] >  cur_cfg[63:32]);
      endcase
    end
    cmd_ok      = !cur_cfg[1] || (msg_packet[45:40] == cur_cfg[31:26]);
    tx_ok       = !cur_cfg[0] || (msg_packet[46] == cur_cfg[25]);
    stage_match = arg_ok && cmd_ok && tx_ok;
  end

  // Writable configuration: CTRL fields and the four stage descriptors.
  always_ff @(posedge clk) begin
    if (reset_i) begin
      ctrl_last    <= '0;
      ctrl_rearm   <= 1'b0;
      ctrl_timeout <= '0;
      for (int i = 0; i < 4; i++) stage_cfg[i] <= '0;
    end else if (reg_write) begin
      if (reg_address == ADDR_CTRL) begin
        case (reg_bytecnt)
          16'd0: begin
            ctrl_last  <= reg_datai[1:0];
            ctrl_rearm <= reg_datai[3];
          end
          16'd2:   ctrl_timeout[7:0]  <= reg_datai;
          16'd3:   ctrl_timeout[15:8] <= reg_datai;
          default: ;
        endcase
      end else if ((reg_address == ADDR_STAGES) && (reg_bytecnt < 16'd32)) begin
        stage_cfg[reg_bytecnt[4:3]][{reg_bytecnt[2:0], 3'b000} +: 8] <= reg_datai;
      end
    end
  end

  // Sequencer: abort beats arm, and both override normal state progress.
  always_ff @(posedge clk) begin
    if (reset_i) begin
      state       <= ST_IDLE;
      stage       <= '0;
      miss_cnt    <= '0;
      fire_cnt    <= '0;
      stretch_cnt <= '0;
      trig_out    <= 1'b0;
    end else if (abort_strobe) begin
      state    <= ST_IDLE;
      stage    <= '0;
      miss_cnt <= '0;
      trig_out <= 1'b0;
    end else if (arm_strobe) begin
      state    <= ST_WAIT;
      stage    <= '0;
      miss_cnt <= '0;
      fire_cnt <= '0;
      trig_out <= 1'b0;
    end else begin
      case (state)
        ST_WAIT: begin
          if (msg_valid) begin
            if (stage_match) begin
              if (stage >= ctrl_last) begin
                state       <= ST_FIRE;
                trig_out    <= 1'b1;
                stretch_cnt <= STRETCH_M1;
                if (fire_cnt != 8'hFF) fire_cnt <= fire_cnt + 8'd1;
              end else begin
                stage    <= stage + 2'd1;
                miss_cnt <= '0;
              end
            end else if ((stage != 2'd0) && (ctrl_timeout != 16'd0)) begin
              if (miss_next == ctrl_timeout) begin
                stage    <= '0;
                miss_cnt <= '0;
              end else begin
                miss_cnt <= miss_next;
              end
            end
          end
        end
        ST_FIRE: begin
          if (stretch_cnt == 8'd0) begin
            trig_out <= 1'b0;
            stage    <= '0;
            miss_cnt <= '0;
            state    <= ctrl_rearm ? ST_WAIT : ST_IDLE;
          end else begin
            stretch_cnt <= stretch_cnt - 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // Read-back byte selection; bytes past the register length read 0.
  always_comb begin
    rd_byte = '0;
    case (reg_address)
      ADDR_STATUS: if (reg_bytecnt < 16'd2)
                     rd_byte = reg_bytecnt[0] ? status_word[15:8] : status_word[7:0];
      ADDR_CTRL:   if (reg_bytecnt < 16'd4)
                     rd_byte = ctrl_word[{reg_bytecnt[1:0], 3'b000} +: 8];
      ADDR_STAGES: if (reg_bytecnt < 16'd32)
                     rd_byte = stage_cfg[reg_bytecnt[4:3]][{reg_bytecnt[2:0], 3'b000} +: 8];
      default:     rd_byte = '0;
    endcase
  end

  // Register length lookup for the bus host.
  always_comb begin
    case (reg_hypaddress)
      ADDR_STATUS: reg_hyplen = 16'd2;
      ADDR_CTRL:   reg_hyplen = 16'd4;
      ADDR_STAGES: reg_hyplen = 16'd32;
      default:     reg_hyplen = 16'd0;
    endcase
  end

  // Registered read data, updated only on a read strobe.
  always_ff @(posedge clk) begin
    if (reset_i) reg_datao <= '0;
    else if (reg_read) reg_datao <= rd_byte;
  end

endmodule
